ase_reset_sequencer: RTL and testbench

Synthesizable scheduler for the shared AFU soft-reset resource in the ASE simulation environment. Collects reset requests from NUM_REQ independent requesters (SW MMIO path, protocol shims, error handlers). Sequences each reset as a batch: quiesce traffic (lockdown), wait for system idle with a timeout, hold soft reset, then a post-reset settle window. Completion is acknowledged per requester. Sits between the protocol-specific top and the AFU, alongside the ASE reset/idle logic.

---
 rtl/ase_reset_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ase_reset_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ase_reset_sequencer.sv
// ---------------------------------------------------------------------------
// ase_reset_sequencer
//
// Schedules the shared AFU soft reset for NUM_REQ independent requesters.
// Requests are collected into a batch and served by one sequence:
//   LOCK    : lockdown high, wait for system_is_idle (bounded by IDLE_TIMEOUT)
//   ASSERT  : soft_reset held high for HOLD_CYCLES cycles
//   RELEASE : POST_CYCLES settle cycles, then a one-cycle req_ack for the batch
// Requests arriving while a sequence runs are parked in a pending mask and
// start a fresh sequence after one IDLE cycle.
//
// Ports
//   clk            : single clock, all logic on posedge
//   ase_reset      : synchronous active-high system reset
//   req_valid      : per-requester reset request pulse (a level repeats)
//   system_is_idle : no transactions in flight (sampled only in LOCK)
//   lockdown       : stop accepting new transactions
//   soft_reset     : AFU soft reset (high during ase_reset)
//   req_ack        : one-cycle completion pulse, one bit per served requester
//   timeout_err    : one-cycle pulse, idle wait timed out and reset was forced
//   busy           : sequencer is not idle
// All outputs are registered.
// ---------------------------------------------------------------------------
module ase_reset_sequencer #(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int HOLD_CYCLES  = 20,
  parameter int POST_CYCLES  = 20
) (
  input  logic               clk,
  input  logic               ase_reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               system_is_idle,
  output logic               lockdown,
  output logic               soft_reset,
  output logic [NUM_REQ-1:0] req_ack,
  output logic               timeout_err,
  output logic               busy
);

  localparam int MAX_HP  = (HOLD_CYCLES > POST_CYCLES) ? HOLD_CYCLES : POST_CYCLES;
  localparam int MAX_ALL = (IDLE_TIMEOUT > MAX_HP) ? IDLE_TIMEOUT : MAX_HP;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] TO_LAST   = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK    = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] r_served;
  logic [CW-1:0]      r_wait_cnt;
  logic [CW-1:0]      r_cnt;
  logic               r_lockdown;
  logic               r_soft_reset;
  logic [NUM_REQ-1:0] r_req_ack;
  logic               r_timeout_err;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] w_req_all;
  logic [NUM_REQ-1:0] w_pending_nxt;
  logic [NUM_REQ-1:0] w_served_nxt;
  logic [CW-1:0]      w_wait_cnt_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_lockdown_nxt;
  logic               w_soft_reset_nxt;
  logic [NUM_REQ-1:0] w_req_ack_nxt;
  logic               w_timeout_err_nxt;
  logic               w_busy_nxt;

  assign w_req_all = r_pending | req_valid;

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    w_state_nxt       = r_state;
    // New requests accumulate in every state; IDLE overrides when it takes them.
    w_pending_nxt     = w_req_all;
    w_served_nxt      = r_served;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_cnt_nxt         = r_cnt;
    w_lockdown_nxt    = r_lockdown;
    w_soft_reset_nxt  = r_soft_reset;
    w_req_ack_nxt     = '0;
    w_timeout_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Also releases the soft reset left high by ase_reset.
        w_soft_reset_nxt = 1'b0;
        w_lockdown_nxt   = 1'b0;
        if (w_req_all != '0) begin
          w_state_nxt    = ST_LOCK;
          w_served_nxt   = w_req_all;
          w_pending_nxt  = '0;
          w_lockdown_nxt = 1'b1;
          w_wait_cnt_nxt = '0;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end

      ST_LOCK: begin
        if (system_is_idle) begin
          w_state_nxt      = ST_ASSERT;
          w_soft_reset_nxt = 1'b1;
          w_cnt_nxt        = '0;
        end else if (r_wait_cnt == TO_LAST) begin
          // Traffic never drained; force the reset anyway and flag it.
          w_state_nxt       = ST_ASSERT;
          w_soft_reset_nxt  = 1'b1;
          w_timeout_err_nxt = 1'b1;
          w_cnt_nxt         = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
        end
      end

      ST_ASSERT: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt      = ST_RELEASE;
          w_soft_reset_nxt = 1'b0;
          w_cnt_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      ST_RELEASE: begin
        if (r_cnt == POST_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_lockdown_nxt = 1'b0;
          w_req_ack_nxt  = r_served;
          w_served_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt      = ST_IDLE;
        w_lockdown_nxt   = 1'b0;
        w_soft_reset_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs; ase_reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (ase_reset) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      r_served      <= '0;
      r_wait_cnt    <= '0;
      r_cnt         <= '0;
      r_lockdown    <= 1'b0;
      r_soft_reset  <= 1'b1;
      r_req_ack     <= '0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_pending_nxt;
      r_served      <= w_served_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_cnt         <= w_cnt_nxt;
      r_lockdown    <= w_lockdown_nxt;
      r_soft_reset  <= w_soft_reset_nxt;
      r_req_ack     <= w_req_ack_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign lockdown    = r_lockdown;
  assign soft_reset  = r_soft_reset;
  assign req_ack     = r_req_ack;
  assign timeout_err = r_timeout_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ase_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ase_reset_sequencer
//
// Drives directed scenarios followed by randomized traffic into
// ase_reset_sequencer and compares every output, every cycle, against a
// timestamp-based reference model: a batch starts at edge t_lock, the reset
// fires at edge t_fire (idle seen or t_lock+TIMEOUT), soft_reset is high for
// edges [t_fire, t_fire+HOLD) and the ack lands on edge t_fire+HOLD+POST.
// ---------------------------------------------------------------------------
module tb_ase_reset_sequencer;

  localparam int NR   = 2;
  localparam int TOUT = 8;
  localparam int HOLD = 4;
  localparam int POST = 3;

  logic          clk;
  logic          ase_reset;
  logic [NR-1:0] req_valid;
  logic          system_is_idle;
  logic          lockdown;
  logic          soft_reset;
  logic [NR-1:0] req_ack;
  logic          timeout_err;
  logic          busy;

  ase_reset_sequencer #(
    .NUM_REQ      (NR),
    .IDLE_TIMEOUT (TOUT),
    .HOLD_CYCLES  (HOLD),
    .POST_CYCLES  (POST)
  ) dut (
    .clk            (clk),
    .ase_reset      (ase_reset),
    .req_valid      (req_valid),
    .system_is_idle (system_is_idle),
    .lockdown       (lockdown),
    .soft_reset     (soft_reset),
    .req_ack        (req_ack),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (edge-index timestamps).
  int            edge_no = 0;
  bit            in_seq  = 1'b0;
  int            t_lock  = 0;
  int            t_fire  = -1;
  bit [NR-1:0]   m_pend  = '0;
  bit [NR-1:0]   m_serv  = '0;
  bit            e_lock, e_soft, e_to, e_busy;
  bit [NR-1:0]   e_ack;
  int            n_soft_rise = 0;
  int            n_ack_pulses = 0;
  bit            prev_soft = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_no, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge with the given inputs.
  task automatic model_edge(input bit [NR-1:0] rv, input bit idle, input bit ar);
    edge_no++;
    e_ack = '0;
    e_to  = 1'b0;
    if (ar) begin
      in_seq = 1'b0;
      m_pend = '0;
      m_serv = '0;
      e_lock = 1'b0;
      e_soft = 1'b1;
      e_busy = 1'b0;
      return;
    end
    if (!in_seq) begin
      if ((m_pend | rv) != '0) begin
        in_seq = 1'b1;
        m_serv = m_pend | rv;
        m_pend = '0;
        t_lock = edge_no;
        t_fire = -1;
      end
    end else begin
      m_pend = m_pend | rv;
      if (t_fire < 0) begin
        if (idle) begin
          t_fire = edge_no;
        end else if (edge_no - t_lock == TOUT) begin
          t_fire = edge_no;
          e_to   = 1'b1;
        end
      end else if (edge_no == t_fire + HOLD + POST) begin
        e_ack  = m_serv;
        m_serv = '0;
        in_seq = 1'b0;
      end
    end
    e_lock = in_seq;
    e_busy = in_seq;
    e_soft = in_seq && (t_fire >= 0) && (edge_no >= t_fire) && (edge_no < t_fire + HOLD);
  endtask

  // Apply one cycle of stimulus and check every output after the edge.
  task automatic cyc(input bit [NR-1:0] rv, input bit idle, input bit ar);
    @(negedge clk);
    req_valid      = rv;
    system_is_idle = idle;
    ase_reset      = ar;
    @(posedge clk);
    model_edge(rv, idle, ar);
    #1;
    chk("lockdown",    32'(lockdown),    32'(e_lock));
    chk("soft_reset",  32'(soft_reset),  32'(e_soft));
    chk("req_ack",     32'(req_ack),     32'(e_ack));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
    chk("busy",        32'(busy),        32'(e_busy));
    if (soft_reset && !prev_soft && !ar) n_soft_rise++;
    if (req_ack != '0) n_ack_pulses++;
    prev_soft = soft_reset;
  endtask

  initial begin
    int base_rise;
    int base_ack;
    ase_reset      = 1'b1;
    req_valid      = '0;
    system_is_idle = 1'b1;

    // Reset state.
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, 1'b1);
    cyc(2'b00, 1'b1, 1'b0);
    chk("soft_released_after_reset", 32'(soft_reset), 32'd0);

    // Single request, idle already high.
    cyc(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(2'b00, 1'b1, 1'b0);

    // Idle never arrives: forced reset with timeout_err.
    cyc(2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(2'b00, 1'b0, 1'b0);

    // Idle low for 3 LOCK cycles, then high.
    cyc(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(2'b00, 1'b1, 1'b0);

    // Re-requests during ASSERT: two sequences, acks 01 then 11.
    base_rise = n_soft_rise;
    base_ack  = n_ack_pulses;
    cyc(2'b01, 1'b1, 1'b0);
    cyc(2'b00, 1'b1, 1'b0);
    cyc(2'b10, 1'b1, 1'b0);
    cyc(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) cyc(2'b00, 1'b1, 1'b0);
    chk("two_soft_pulses", 32'(n_soft_rise - base_rise), 32'd2);
    chk("two_ack_pulses",  32'(n_ack_pulses - base_ack), 32'd2);

    // Both requesters in the same cycle.
    cyc(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(2'b00, 1'b1, 1'b0);

    // ase_reset mid-ASSERT abandons the sequence without an ack.
    base_ack = n_ack_pulses;
    cyc(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, 1'b0);
    cyc(2'b00, 1'b1, 1'b1);
    cyc(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) cyc(2'b00, 1'b1, 1'b0);
    chk("no_ack_after_abort", 32'(n_ack_pulses - base_ack), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit [NR-1:0] rv;
      bit          idle;
      bit          ar;
      rv[0] = ($urandom_range(0, 7) == 0);
      rv[1] = ($urandom_range(0, 7) == 0);
      idle  = ($urandom_range(0, 9) < 6);
      ar    = ($urandom_range(0, 299) == 0);
      cyc(rv, idle, ar);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
